ss_sched: RTL
=============

SS_SCHED -- requirements
Module: ss_sched

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 16, meaning maximum words per grant; legal range 1..255.
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port wb_rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port ss_start, input, 4 bits: per-channel "ready to move data" (FIFO half-empty/half-full).
REQ-005 The block SHALL have port ss_stop, input, 4 bits: per-channel "stop now" (FIFO almost full/empty).
REQ-006 The block SHALL have port ss_end, input, 4 bits: per-channel "current word is the last of the transfer".
REQ-007 The block SHALL have port ss_xfer, output, 4 bits: one-hot per-channel FIFO strobe, one word per high cycle.
REQ-008 The block SHALL have port ss_last, output, 4 bits: last-word tag accompanying ss_xfer toward a source FIFO.
REQ-009 The block SHALL have port eng_req, output, 1 bit: a burst is granted and open to the bus engine.
REQ-010 The block SHALL have port eng_ch, output, 2 bits: the granted channel index, stable while eng_req is high.
REQ-011 The block SHALL have port eng_rdy, output, 1 bit: the granted channel can take/give a word this cycle.
REQ-012 The block SHALL have port eng_vld, input, 1 bit: the engine moves one word this cycle.
REQ-013 The block SHALL have port eng_last, input, 1 bit: the engine marks the current word as the descriptor's last word.
REQ-014 The block SHALL have port eng_done, output, 1 bit: one-cycle pulse at burst close.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ARB, XFER and GAP.
REQ-017 Channel c SHALL be eligible when ss_start[c] is 1 and ss_stop[c] is 0.
REQ-018 IDLE SHALL go to ARB when any channel is eligible, and otherwise stay in IDLE.
REQ-019 ARB SHALL last one cycle and register the grant g as the first eligible channel searching upward from rr_ptr, modulo 4.
REQ-020 If no channel is eligible in ARB, the FSM SHALL return to IDLE without a grant.
REQ-021 In XFER, eng_req SHALL be 1, eng_ch SHALL equal g, and eng_rdy SHALL equal !ss_stop[g], combinational.
REQ-022 ss_xfer[g] SHALL equal eng_rdy & eng_vld in XFER; all other ss_xfer bits SHALL be 0; ss_xfer SHALL be 0 outside XFER.
REQ-023 ss_last[g] SHALL equal ss_xfer[g] & eng_last.
REQ-024 An 8-bit word counter SHALL clear on entry to XFER and increment on each ss_xfer[g].
REQ-025 XFER SHALL go to GAP after a cycle in which any of the following holds: ss_stop[g]; (ss_xfer[g] & ss_end[g]); ss_last[g]; or the count reaches BURST_MAX (subject to REQ-032).
REQ-026 Simultaneous close conditions SHALL produce exactly one transition to GAP and exactly one eng_done pulse.
REQ-027 Deassertion of ss_start[g] during XFER SHALL be ignored.
REQ-028 GAP SHALL last one cycle, pulse eng_done, set rr_ptr to (g+1) mod 4, and go to IDLE.
REQ-029 GAP SHALL guarantee at least one non-XFER cycle between bursts.
REQ-030 Latency from eligibility in IDLE to first possible ss_xfer SHALL be 2 cycles.

Reset
REQ-031 Assertion of wb_rst_ni low SHALL immediately force: state IDLE, rr_ptr 0, g 0, counter 0, and all outputs 0 (ss_xfer, ss_last, eng_req, eng_ch, eng_rdy, eng_done, busy), including mid-burst; the first arbitration after release SHALL search from channel 0.

Configuration
REQ-032 With macro SS_SCHED_BURST_LIMIT_EN defined, a burst SHALL close when the count reaches BURST_MAX; without it, the counter and the limit SHALL be absent and bursts SHALL close only on stop, end or last.

Verification
REQ-033 Directed test, single channel: ss_start=0001, eng_vld held 1, BURST_MAX=16, macro on -> ss_xfer[0] high exactly 16 cycles starting 2 cycles after start, then one eng_done pulse.
REQ-034 Directed test, round robin: ss_start=1111 held, four bursts -> eng_ch sequence 0,1,2,3,0, with one GAP cycle between bursts.
REQ-035 Directed test, stop: ss_stop[2] rises on word 5 of a channel-2 burst -> eng_rdy=0 and no xfer that cycle, GAP next, eng_done once.
REQ-036 Directed test, simultaneous close: eng_last=1 and ss_end[1]=1 on word 16 with macro on -> ss_last[1] on that word, exactly one eng_done pulse.
REQ-037 Directed test, reset mid-burst: wb_rst_ni low on word 3 -> all outputs 0 in the same cycle; after release with ss_start=1000, grant goes to channel 3 with the search starting from channel 0.
REQ-038 Directed test, macro off: 300 words with eng_vld=1 and no stop -> a single uninterrupted burst that ends only on eng_last.

Source files
------------

// File: rtl/ss_sched.sv
// Four-channel round-robin burst scheduler between slave FIFOs and a bus engine.
// Define SS_SCHED_BURST_LIMIT_EN to also close bursts after BURST_MAX words.
module ss_sched #(
   parameter int BURST_MAX = 16
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_ni,
   input  logic [3:0] ss_start,
   input  logic [3:0] ss_stop,
   input  logic [3:0] ss_end,
   output logic [3:0] ss_xfer,
   output logic [3:0] ss_last,
   output logic       eng_req,
   output logic [1:0] eng_ch,
   output logic       eng_rdy,
   input  logic       eng_vld,
   input  logic       eng_last,
   output logic       eng_done,
   output logic       busy
);

   if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
      $error("ss_sched: BURST_MAX must be within 1..255");
   end

   typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} state_t;

   state_t     state_q, state_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [1:0] g_q, g_d;
   logic [3:0] eligible;
   logic       found;
   logic [1:0] pick;
   logic [1:0] cand;
   logic       xfer_g;
   logic       limit_hit;
   logic       close;

`ifdef SS_SCHED_BURST_LIMIT_EN
   logic [7:0] cnt_q, cnt_d;
`endif

   assign eligible = ss_start & ~ss_stop;

   // First eligible channel at or above rr_ptr, wrapping modulo 4.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      cand  = rr_ptr_q;
      for (int i = 0; i < 4; i++) begin
         cand = rr_ptr_q + 2'(i);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      eng_req  = (state_q == XFER);
      eng_ch   = eng_req ? g_q : 2'd0;
      eng_rdy  = eng_req & ~ss_stop[g_q];
      xfer_g   = eng_rdy & eng_vld;
      ss_xfer  = xfer_g ? (4'b0001 << g_q) : 4'b0000;
      ss_last  = (xfer_g & eng_last) ? (4'b0001 << g_q) : 4'b0000;
      eng_done = (state_q == GAP);
      busy     = (state_q != IDLE);
   end

`ifdef SS_SCHED_BURST_LIMIT_EN
   assign limit_hit = ((cnt_q + 8'(xfer_g)) == 8'(BURST_MAX));
`else
   assign limit_hit = 1'b0;
`endif

   // All close causes merge into one flag, so coincident causes still yield a single GAP.
   assign close = ss_stop[g_q] | (xfer_g & ss_end[g_q]) | (xfer_g & eng_last) | limit_hit;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      g_d      = g_q;
`ifdef SS_SCHED_BURST_LIMIT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (|eligible) state_d = ARB;
         end
         ARB: begin
            if (found) begin
               g_d     = pick;
               state_d = XFER;
`ifdef SS_SCHED_BURST_LIMIT_EN
               cnt_d   = 8'd0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
`ifdef SS_SCHED_BURST_LIMIT_EN
            cnt_d = cnt_q + 8'(xfer_g);
`endif
            if (close) state_d = GAP;
         end
         GAP: begin
            rr_ptr_d = g_q + 2'd1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= IDLE;
         rr_ptr_q <= 2'd0;
         g_q      <= 2'd0;
`ifdef SS_SCHED_BURST_LIMIT_EN
         cnt_q    <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         g_q      <= g_d;
`ifdef SS_SCHED_BURST_LIMIT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule
